// File: rtl/rcas_pkg.sv
// Shared definitions for the ripple-carry add/sub operand sequencer.
//   - state_e   : FSM state encodings (LOAD_B..SHOW, encoded 0..4)
//   - WIDTH_DEF : default operand/result width
//   - OP_ADD/OP_SUB : values of the operation-select switch
//   - REARM_CYCLES  : cycles a button must read low before it may pulse again
package rcas_pkg;

  localparam int WIDTH_DEF = 3;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Contact bounce produces short low gaps while a button is being pressed or
  // released; a new pulse is only allowed once the line has been quiet for
  // this many cycles.
  localparam int REARM_CYCLES = 8;

  typedef enum logic [2:0] {
    LOAD_B  = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_OP = 3'd2,
    CAPTURE = 3'd3,
    SHOW    = 3'd4
  } state_e;

endpackage

// File: rtl/rcas_operand_sequencer_btn_pulse.sv
// Button conditioner: SYNC_STAGES-deep synchroniser followed by a rising-edge
// detector with a re-arm lockout, so each physical press produces a single
// one-cycle pulse regardless of hold time or contact bounce.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   btn     : raw asynchronous button input
//   pulse   : registered one-cycle pulse, SYNC_STAGES+1 cycles after press
module btn_pulse
  import rcas_pkg::*;
#(
  parameter int SYNC_STAGES = 2  // minimum 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(REARM_CYCLES + 1);
  localparam logic [CW-1:0] REARM_MAX = CW'(REARM_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   armed_q;
  logic [CW-1:0]          low_cnt_q;
  logic                   pulse_q;
  logic                   level;
  logic                   rise;

  // Synchroniser chain: stage 0 samples the raw pin, each later stage
  // samples its predecessor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q[0] <= 1'b0;
    else        sync_q[0] <= btn;
  end

  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q[gi] <= 1'b0;
      else        sync_q[gi] <= sync_q[gi-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= 1'b0;
      armed_q   <= 1'b1;
      low_cnt_q <= REARM_MAX;
      pulse_q   <= 1'b0;
    end else begin
      prev_q  <= level;
      // Only the first edge after a quiet period fires; bounce edges that
      // follow it find armed_q already cleared.
      pulse_q <= rise & armed_q;

      if (level)                       low_cnt_q <= '0;
      else if (low_cnt_q != REARM_MAX) low_cnt_q <= low_cnt_q + CW'(1);

      if (rise)                        armed_q <= 1'b0;
      else if (low_cnt_q == REARM_MAX) armed_q <= 1'b1;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/rcas_operand_sequencer.sv
// Operand-entry and result-capture controller for the ripple-carry add/sub
// stage. Operands B, A and the operation select are latched from switches on
// successive "next" presses; one cycle later the stage's S/Cout are captured
// and signed overflow is flagged.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   sw, sw_op           : operand switches, operation select (0 add, 1 sub)
//   btn_next, btn_clr   : raw buttons (advance / return to entry)
//   op_a, op_b, op_con  : registered operands and con to the add/sub stage
//   sum_in, cout_in     : S and Cout returned from the add/sub stage
//   result, result_cout : captured S and Cout
//   overflow            : signed overflow of the captured result
//   result_valid        : high while the captured outputs are valid
//   state_code          : FSM state for LEDs
module rcas_operand_sequencer
  import rcas_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             sw_op,
  input  logic             btn_next,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_con,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             cout_in,
  output logic [WIDTH-1:0] result,
  output logic             result_cout,
  output logic             overflow,
  output logic             result_valid,
  output logic [1:0]       state_code
);

  localparam int MSB = WIDTH - 1;

  logic next_p;
  logic clr_p;

  btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_next (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_next),
    .pulse (next_p)
  );

  btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clr),
    .pulse (clr_p)
  );

  state_e           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             op_con_q;
  logic [WIDTH-1:0] result_q;
  logic             result_cout_q;
  logic             overflow_q;
  logic             result_valid_q;
  logic             ovf_d;

  // Subtract flips A's effective sign, so overflow needs like effective signs
  // going in and a different sign coming out.
  assign ovf_d = (op_con_q ? (op_b_q[MSB] != op_a_q[MSB])
                           : (op_b_q[MSB] == op_a_q[MSB]))
                 && (sum_in[MSB] != op_b_q[MSB]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= LOAD_B;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_con_q       <= 1'b0;
      result_q       <= '0;
      result_cout_q  <= 1'b0;
      overflow_q     <= 1'b0;
      result_valid_q <= 1'b0;
    end else if (clr_p) begin
      // Clear overrides any simultaneous next press.
      state_q        <= LOAD_B;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_con_q       <= 1'b0;
      result_q       <= '0;
      result_cout_q  <= 1'b0;
      overflow_q     <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD_B: if (next_p) begin
          op_b_q  <= sw;
          state_q <= LOAD_A;
        end
        LOAD_A: if (next_p) begin
          op_a_q  <= sw;
          state_q <= LOAD_OP;
        end
        LOAD_OP: if (next_p) begin
          op_con_q <= sw_op;
          state_q  <= CAPTURE;
        end
        // Operands have been stable for a full cycle here, so the ripple
        // path has settled; next_p is deliberately not examined.
        CAPTURE: begin
          result_q       <= sum_in;
          result_cout_q  <= cout_in;
          overflow_q     <= ovf_d;
          result_valid_q <= 1'b1;
          state_q        <= SHOW;
        end
        SHOW: if (next_p) begin
          result_valid_q <= 1'b0;
          state_q        <= LOAD_B;
        end
        default: state_q <= LOAD_B;
      endcase
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_con       = op_con_q;
  assign result       = result_q;
  assign result_cout  = result_cout_q;
  assign overflow     = overflow_q;
  assign result_valid = result_valid_q;
  // CAPTURE lasts one cycle and is shown as 0 rather than flashing code 3.
  assign state_code   = (state_q == CAPTURE) ? 2'd0 : state_q[1:0];

endmodule

// File: tb/tb_rcas_operand_sequencer.sv
module tb_rcas_operand_sequencer;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw = '0;
  logic         sw_op = 1'b0;
  logic         btn_next = 1'b0;
  logic         btn_clr = 1'b0;
  logic [W-1:0] op_a, op_b;
  logic         op_con;
  logic [W-1:0] sum_in;
  logic         cout_in;
  logic [W-1:0] result;
  logic         result_cout;
  logic         overflow;
  logic         result_valid;
  logic [1:0]   state_code;

  int checks = 0;
  int errors = 0;

  logic [4:0] sb_q[$];  // {result, cout, overflow}

  always #5 clk = ~clk;

  // External add/sub stage: B + (A ^ con) + con.
  assign {cout_in, sum_in} = {1'b0, op_b} + {1'b0, (op_a ^ {W{op_con}})} + {3'b000, op_con};

  rcas_operand_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .sw_op        (sw_op),
    .btn_next     (btn_next),
    .btn_clr      (btn_clr),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_con       (op_con),
    .sum_in       (sum_in),
    .cout_in      (cout_in),
    .result       (result),
    .result_cout  (result_cout),
    .overflow     (overflow),
    .result_valid (result_valid),
    .state_code   (state_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signed-integer reference: result bits, no-borrow/carry, range overflow.
  function automatic logic [4:0] model(input int b, input int a, input int op);
    int sb, sa, r;
    logic [2:0] res;
    logic c, v;
    sb  = (b > 3) ? b - 8 : b;
    sa  = (a > 3) ? a - 8 : a;
    r   = op ? (sb - sa) : (sb + sa);
    res = r[2:0];
    v   = (r > 3) || (r < -4);
    c   = op ? (b >= a) : ((b + a) > 7);
    return {res, c, v};
  endfunction

  task automatic press_next();
    @(negedge clk) btn_next = 1'b1;
    repeat (4) @(negedge clk);
    btn_next = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic press_clr();
    @(negedge clk) btn_clr = 1'b1;
    repeat (4) @(negedge clk);
    btn_clr = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic run_op(input int b, input int a, input int op);
    logic [4:0] e;
    int n;
    sw = W'(b);
    press_next();
    chk("op_b_load", op_b, b);
    chk("state_after_b", state_code, 1);
    sw = W'(a);
    press_next();
    chk("op_a_load", op_a, a);
    chk("state_after_a", state_code, 2);
    sw_op = op[0];
    sb_q.push_back(model(b, a, op));
    // Drive the last press and time result_valid relative to it.
    @(negedge clk) btn_next = 1'b1;
    n = 0;
    while (!result_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", {31'd0, result_valid}, 1);
    // Press seen before edge1; pulse after edge 3; capture after edge 5.
    chk("valid_latency", n, 5);
    repeat (3) @(negedge clk);
    btn_next = 1'b0;
    repeat (16) @(negedge clk);
    chk("state_show", state_code, 0);
    chk("op_con_load", op_con, op);
    chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("result", result, e[4:2]);
      chk("result_cout", result_cout, e[1]);
      chk("overflow", overflow, e[0]);
    end
    $display("txn B=%0d A=%0d op=%0d -> result=%b cout=%b ovf=%b valid=%b",
             b, a, op, result, result_cout, overflow, result_valid);
  endtask

  task automatic ack_show();
    press_next();
    chk("ack_valid", result_valid, 0);
    chk("ack_state", state_code, 0);
  endtask

  initial begin
    int trans;
    logic [1:0] prev_sc;

    repeat (3) @(negedge clk);
    chk("rst_state", state_code, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_ops", {op_a, op_b, op_con}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(3, 2, 0);   // 3+2 overflows to 101
    ack_show();
    run_op(5, 6, 1);   // -3 - -2 = -1
    ack_show();
    run_op(2, 2, 1);   // zero result, no borrow
    ack_show();
    run_op(7, 1, 0);   // wraps to 0 with carry
    ack_show();

    // Bouncy long press: one advance only.
    trans = 0;
    prev_sc = state_code;
    sw = 3'd4;
    for (int i = 0; i < 66; i++) begin
      @(negedge clk);
      if (i < 5)       btn_next = i[0] ? 1'b0 : 1'b1;
      else if (i < 50) btn_next = 1'b1;
      else             btn_next = 1'b0;
      if (state_code != prev_sc) trans++;
      prev_sc = state_code;
    end
    chk("bounce_trans", trans, 1);
    chk("bounce_state", state_code, 1);
    $display("txn bounce press -> transitions=%0d state=%0d", trans, state_code);

    // Clear from LOAD_OP.
    sw = 3'd3;
    press_next();
    chk("pre_clr_state", state_code, 2);
    press_clr();
    chk("clr_state", state_code, 0);
    chk("clr_ops", {op_a, op_b, op_con}, 0);
    chk("clr_valid", result_valid, 0);
    $display("txn clear in LOAD_OP -> state=%0d a=%0d b=%0d", state_code, op_a, op_b);

    // Clear and next together.
    sw = 3'd6;
    press_next();
    sw = 3'd5;
    press_next();
    chk("pre_both_state", state_code, 2);
    @(negedge clk) begin btn_next = 1'b1; btn_clr = 1'b1; end
    repeat (4) @(negedge clk);
    btn_next = 1'b0;
    btn_clr  = 1'b0;
    repeat (16) @(negedge clk);
    chk("both_state", state_code, 0);
    chk("both_ops", {op_a, op_b, op_con}, 0);
    chk("both_valid", result_valid, 0);
    $display("txn clear+next -> state=%0d a=%0d b=%0d con=%0d", state_code, op_a, op_b, op_con);

    // Asynchronous reset mid-SHOW, between edges.
    run_op(6, 3, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", result_valid, 0);
    chk("arst_result", {result, result_cout, overflow}, 0);
    chk("arst_ops", {op_a, op_b, op_con}, 0);
    chk("arst_state", state_code, 0);
    $display("txn async reset -> valid=%b result=%b ops=%0d/%0d", result_valid, result, op_a, op_b);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_op(4, 1, 1);   // -4 - 1 overflows
    ack_show();

    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
